// File: rtl/nios2_rcv_data_mailbox_if.sv
`default_nettype none
// ============================================================================
// Module      : nios2_rcv_data_mailbox_if
// Description : Fabric receive handshake plus Avalon-MM slave bundle for the
//               NIOS2 receive-data mailbox.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios2_rcv_data_mailbox_if #(
    parameter int DATA_W = 32
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;
    logic              read_over;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              data_ready;
    logic              irq;

    modport slave (
        input  rx_valid, rx_data, read_over, address, chipselect, write_n, writedata,
        output rx_ready, readdata, data_ready, irq
    );

    modport master (
        output rx_valid, rx_data, read_over, address, chipselect, write_n, writedata,
        input  rx_ready, readdata, data_ready, irq
    );
endinterface
`default_nettype wire

// File: rtl/nios2_rcv_data_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : nios2_rcv_data_mailbox
// Description : Receive FIFO between fabric and NIOS2; CPU reads head/status
//               over Avalon-MM and pops on a rising edge of read_over.
//               Optional CONTROL register / irq under NIOS2_RCV_DATA_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_rcv_data_mailbox #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input wire clk,
    input wire reset,
    nios2_rcv_data_mailbox_if.slave bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               read_over_dly_q, read_over_dly_d;
    logic               underflow_q, underflow_d;
    logic               data_ready_q, data_ready_d;

    logic w_full;
    logic w_not_empty;
    logic w_push;
    logic w_pop_evt;
    logic w_pop;
    logic w_write;
    logic [31:0] w_readdata;
    logic [31:0] w_status;
    logic w_unused_ok;

    assign w_full      = (count_q == c_CNT_W'(DEPTH));
    assign w_not_empty = (count_q != '0);
    assign w_push      = bus.rx_valid && !w_full;
    assign w_pop_evt   = bus.read_over && !read_over_dly_q;
    // An acknowledge against an empty FIFO never moves pointers, even with a same-cycle push.
    assign w_pop       = w_pop_evt && w_not_empty;
    assign w_write     = bus.chipselect && !bus.write_n;
    assign w_unused_ok = ^bus.writedata;

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        underflow_d     = underflow_q;
        read_over_dly_d = bus.read_over;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_W'(1);
        end

        if (w_pop_evt && !w_not_empty) begin
            underflow_d = 1'b1;
        end else if (w_write && (bus.address == 2'd1) && bus.writedata[2]) begin
            underflow_d = 1'b0;
        end

        data_ready_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            read_over_dly_q <= 1'b0;
            underflow_q     <= 1'b0;
            data_ready_q    <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            read_over_dly_q <= read_over_dly_d;
            underflow_q     <= underflow_d;
            data_ready_q    <= data_ready_d;
        end
    end

    // Storage carries no reset; count_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

`ifdef NIOS2_RCV_DATA_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (w_write && (bus.address == 2'd2)) begin
            irq_en_d = bus.writedata[0];
        end
        irq_d = irq_en_q && w_not_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

    assign w_status = {23'd0, 5'(count_q), 1'b0, underflow_q, w_full, w_not_empty};

    always_comb begin
        w_readdata = 32'd0;
        case (bus.address)
            2'd0: w_readdata = w_not_empty ? 32'(mem_q[rd_ptr_q]) : 32'd0;
            2'd1: w_readdata = w_status;
`ifdef NIOS2_RCV_DATA_IRQ_EN
            2'd2: w_readdata = {31'd0, irq_en_q};
`endif
            default: w_readdata = 32'd0;
        endcase
    end

    assign bus.readdata   = w_readdata;
    assign bus.rx_ready   = !w_full;
    assign bus.data_ready = data_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_nios2_rcv_data_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_rcv_data_mailbox
// Description : Directed plus randomized bench for the receive-data mailbox,
//               checked against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_rcv_data_mailbox;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    bit [31:0] mdl_q[$];
    bit mdl_uf = 0, mdl_irq_en = 0, mdl_irq = 0, mdl_ro_prev = 0, mdl_pushed = 0;

    always #10 clk = ~clk;

    nios2_rcv_data_mailbox_if #(.DATA_W(32)) bus ();

    nios2_rcv_data_mailbox #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        int sz = mdl_q.size();
        case (a)
            0: return (sz != 0) ? mdl_q[0] : 32'd0;
            1: return {23'd0, 5'(sz), 1'b0, mdl_uf, (sz == DEPTH), (sz != 0)};
`ifdef NIOS2_RCV_DATA_IRQ_EN
            2: return {31'd0, mdl_irq_en};
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock edge, applying the mailbox rules to the inputs seen at that edge.
    task automatic tick();
        int sz      = mdl_q.size();
        bit pop_evt = bus.read_over && !mdl_ro_prev;
        bit push    = bus.rx_valid && (sz < DEPTH);
        bit wr      = bus.chipselect && !bus.write_n;
`ifdef NIOS2_RCV_DATA_IRQ_EN
        mdl_irq = mdl_irq_en && (sz != 0);
        if (wr && bus.address == 2'd2) mdl_irq_en = bus.writedata[0];
`endif
        if (pop_evt && sz == 0) mdl_uf = 1'b1;
        else if (wr && bus.address == 2'd1 && bus.writedata[2]) mdl_uf = 1'b0;
        if (pop_evt && sz != 0) void'(mdl_q.pop_front());
        if (push) mdl_q.push_back(bus.rx_data);
        mdl_pushed  = push;
        mdl_ro_prev = bus.read_over;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 4; a++) begin
            bus.address = 2'(a);
            #1;
            check_eq($sformatf("%s_rd%0d", tag, a), bus.readdata, exp_rd(a));
        end
        check_eq({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(mdl_q.size() != DEPTH));
        check_eq({tag, "_data_ready"}, 32'(bus.data_ready), 32'(mdl_q.size() != 0));
        check_eq({tag, "_irq"}, 32'(bus.irq), 32'(mdl_irq));
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    task automatic push_word(input logic [31:0] d, input string tag);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        tick();
        bus.rx_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic pulse_ro(input string tag);
        bus.read_over = 1'b1;
        tick();
        check_all({tag, "_hi"});
        bus.read_over = 1'b0;
        tick();
        check_all({tag, "_lo"});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input string tag);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        bus.rx_valid   = 1'b0;
        bus.read_over  = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset          = 1'b1;
        #2;
        mdl_q.delete();
        mdl_uf = 0; mdl_irq_en = 0; mdl_irq = 0; mdl_ro_prev = 0; mdl_pushed = 0;
        check_all({tag, "_in"});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all({tag, "_out"});
    endtask

    initial begin
        logic [31:0] rd;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = '0;
        bus.read_over  = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        reset          = 1'b0;
        #3;

        apply_reset("rst");
        check_eq("rst_rx_ready_one", 32'(bus.rx_ready), 32'd1);

        // Two pushes, head and status, then one acknowledge
        push_word(32'hA5, "p1");
        push_word(32'h3C, "p2");
        bus_read(2'd0, rd); check_eq("head_a5", rd, 32'hA5);
        bus_read(2'd1, rd); check_eq("status_21", rd, 32'h21);
        pulse_ro("pop1");
        bus_read(2'd0, rd); check_eq("head_3c", rd, 32'h3C);
        bus_read(2'd1, rd); check_eq("count_1", 32'(rd[8:4]), 32'd1);
        pulse_ro("pop2");

        // Fill, stall a fifth word, release it with one pop
        for (int i = 0; i < DEPTH; i++) push_word($urandom, $sformatf("fill%0d", i));
        bus.rx_valid = 1'b1;
        bus.rx_data  = 32'h77;
        tick();
        check_all("stall");
        check_eq("full_rx_ready0", 32'(bus.rx_ready), 32'd0);
        bus_read(2'd1, rd); check_eq("full_bit", 32'(rd[1]), 32'd1);
        bus.read_over = 1'b1;
        tick();
        check_all("full_pop");
        check_eq("rx_ready_rise", 32'(bus.rx_ready), 32'd1);
        bus.read_over = 1'b0;
        tick();
        bus.rx_valid = 1'b0;
        check_all("accept77");
        bus_read(2'd1, rd); check_eq("count_4", 32'(rd[8:4]), 32'd4);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) pulse_ro($sformatf("wrap%0d_pop%0d", r, i));
            for (int i = 0; i < DEPTH; i++) push_word($urandom, $sformatf("wrap%0d_push%0d", r, i));
        end

        // Level held high pops exactly once
        pulse_ro("to3");
        bus.read_over = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all($sformatf("hold%0d", i));
        end
        bus.read_over = 1'b0;
        tick();
        bus_read(2'd1, rd); check_eq("hold_count_2", 32'(rd[8:4]), 32'd2);

        // Underflow set, clear, and set-beats-clear
        pulse_ro("drain0");
        pulse_ro("drain1");
        pulse_ro("uf_set");
        bus_read(2'd1, rd); check_eq("uf_set_bit", 32'(rd[2]), 32'd1);
        bus_write(2'd1, 32'h4, "uf_clr");
        bus_read(2'd1, rd); check_eq("uf_clr_bit", 32'(rd[2]), 32'd0);
        bus.read_over  = 1'b1;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd1;
        bus.writedata  = 32'h4;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_over  = 1'b0;
        check_all("uf_both");
        bus_read(2'd1, rd); check_eq("uf_set_wins", 32'(rd[2]), 32'd1);
        tick();

        // Interrupt path
        bus_write(2'd2, 32'h1, "irq_en");
        push_word(32'h5A, "irq_push");
        check_eq("irq_dr_first", 32'(bus.data_ready), 32'd1);
        check_eq("irq_lags", 32'(bus.irq), 32'd0);
        tick();
        check_all("irq_wait");
`ifdef NIOS2_RCV_DATA_IRQ_EN
        check_eq("irq_high", 32'(bus.irq), 32'd1);
        bus_read(2'd2, rd); check_eq("ctrl_rd", rd, 32'd1);
`else
        check_eq("irq_tied0", 32'(bus.irq), 32'd0);
        bus_read(2'd2, rd); check_eq("ctrl_absent", rd, 32'd0);
`endif
        pulse_ro("irq_pop");
        check_eq("irq_low", 32'(bus.irq), 32'd0);

        // Randomized traffic with occasional register writes
        for (int c = 0; c < 600; c++) begin
            if (!(bus.rx_valid && !mdl_pushed)) begin
                bus.rx_valid = ($urandom_range(0, 3) != 0) ? (c % 200 < 120) : (c % 200 >= 120);
                bus.rx_data  = $urandom;
            end
            bus.read_over = ($urandom_range(0, (c % 200 < 120) ? 5 : 1) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.address    = 2'($urandom_range(1, 3));
                bus.writedata  = $urandom;
            end else begin
                bus.chipselect = 1'($urandom_range(0, 1));
                bus.write_n    = 1'b1;
            end
            tick();
            bus.chipselect = 1'b0;
            bus.write_n    = 1'b1;
            check_all($sformatf("rnd%0d", c));
        end

        // Reset in the middle of traffic discards the contents
        bus.rx_valid = 1'b0;
        bus.read_over = 1'b0;
        tick();
        push_word(32'h1234, "pre_rst");
        apply_reset("mid_rst");
        bus_read(2'd0, rd); check_eq("mid_rst_head0", rd, 32'd0);
        push_word(32'hBEEF, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios2_rcv_data_mailbox.md
# nios2_rcv_data_mailbox

Receive-side mailbox between the fabric receive path and the NIOS2 CPU. Fabric words enter a small FIFO through a valid/ready handshake. The CPU reads the head word and status over an Avalon-MM slave. The CPU acknowledges consumption by toggling the rcv_data_read_over PIO output high; this block consumes that output, edge-detects it, and pops the FIFO.

## Interface
Parameters:
- DATA_W, 32: fabric word width, 1..32; zero-extended onto readdata.
- DEPTH, 4: FIFO depth in words, power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  fabric word valid.
- rx_data  in  DATA_W  fabric word.
- rx_ready  out  1  FIFO can accept a word; equals !full.
- read_over  in  1  CPU acknowledge level, driven by the rcv_data_read_over PIO out_port.
- address  in  2  Avalon-MM word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address (zero wait states).
- data_ready  out  1  registered; FIFO not empty.
- irq  out  1  registered interrupt; see Configuration.

## Operation
- Register map:
  - addr 0, DATA (RO): head word zero-extended; reads 0 when empty. Reading does not pop.
  - addr 1, STATUS: bit0 not_empty, bit1 full, bit2 underflow (sticky), bits[8:4] count; other bits 0. Writing 1 to bit2 clears underflow.
  - addr 2, CONTROL (RW): bit0 irq_en; other bits read 0.
  - addr 3: reads 0; writes ignored.
- A write occurs on any edge with chipselect && !write_n.
- Push: rx_valid && rx_ready at a clock edge writes rx_data at wr_ptr and increments count. The source must hold rx_valid/rx_data until accepted.
- Pop event: read_over==1 && read_over_d==0, where read_over_d is read_over registered.
  - Not empty: advance rd_ptr and decrement count.
  - Empty: no pointer change; set underflow.
- Simultaneous push and pop (not empty): both take effect; count unchanged.
- Empty with push and pop-event in the same cycle: the pop is treated as underflow; the pushed word remains.
- Full: rx_ready=0, so no push that cycle even if a pop occurs. rx_ready rises the cycle after the pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Underflow clear and set in the same cycle: set wins.
- Reset values: pointers 0, count 0, read_over_d 0, underflow 0, irq_en 0, data_ready 0, irq 0, rx_ready 1. readdata follows the register map, so it is 0 at every address.
- Reset mid-operation discards all FIFO contents. Storage contents need no reset.

## Timing
- Pushed word is visible at addr 0 and in STATUS one cycle after the accepting edge. data_ready rises on that same edge.
- PIO write at edge N sets read_over. The pop occurs at edge N+1, and the new head is readable after edge N+1.
- read_over held high produces exactly one pop. The next pop requires read_over to go low for at least one cycle and then high again.
- irq is registered from irq_en && not_empty, with one cycle of latency after either term changes.
- readdata has no latency relative to address.

## Configuration
- Macro: NIOS2_RCV_DATA_IRQ_EN.
- Defined: CONTROL register exists and irq operates as specified.
- Undefined:
  - irq tied 0.
  - addr 2 reads 0 and writes are ignored.
  - data_ready and all other behaviour are unchanged.

## Test plan
- Reset, then read all four addresses -> all 0; rx_ready=1, data_ready=0, irq=0.
- Push 0xA5, then 0x3C; read addr 0 -> 0xA5, addr 1 -> 0x21; pulse read_over -> addr 0 = 0x3C, count 1.
- Push 4 words (DEPTH=4), hold rx_valid with a fifth word 0x77 -> rx_ready=0 and STATUS full. Pulse read_over -> 0x77 accepted the cycle after rx_ready rises; wrap order preserved over 3 full cycles.
- Hold read_over high for 5 cycles with 3 words queued -> exactly one pop, count 2.
- Pulse read_over when empty -> STATUS bit2=1. Write 0x4 to addr 1 -> bit2=0. Same-cycle underflow and clear -> bit2 stays 1.
- With macro defined: write 1 to addr 2, then push one word -> irq=1 one cycle after data_ready. Pop -> irq=0. Without macro: irq stays 0 and addr 2 reads 0.
